// File: rtl/mean_acc4.sv
// mean_acc4: per-lane sample mean of N = 2^LOG2N MUL4 products.
// Ports:
//   clk_acc      rising-edge clock, shared with MUL4
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse that begins an estimate (ignored while busy)
//   sample_valid sequencer has a sample on MUL4's inputs this cycle
//   en_mul       MUL4 enable; high means a product is issued
//   sample_ack   copy of en_mul; the sequencer advances on it
//   in_data      MUL4 row outputs, lane k at [k*DW +: DW]
//   busy         high from start acceptance through the done cycle
//   done         one-cycle pulse when mean_out takes a new value
//   mean_out     per-lane mean, held until the next done
//   issued_cnt   products issued in the current estimate
module mean_acc4 #(
    parameter int DW    = 26,
    parameter int FRAC  = 13,
    parameter int LOG2N = 10,
    parameter int LAT   = 1,
    parameter int AW    = DW + LOG2N + 1
) (
    input  logic              clk_acc,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sample_valid,
    output logic              en_mul,
    output logic              sample_ack,
    input  logic [4*DW-1:0]   in_data,
    output logic              busy,
    output logic              done,
    output logic [4*DW-1:0]   mean_out,
    output logic [LOG2N:0]    issued_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DIV   = 2'd3;
    localparam int DCW = (LAT > 1) ? $clog2(LAT + 1) : 1;
    localparam logic [LOG2N:0] LAST = (LOG2N + 1)'((1 << LOG2N) - 1);

    // FRAC only documents the Q format; reject values that make no sense.
    if (FRAC < 0 || FRAC >= DW) begin : g_bad_frac
        $error("mean_acc4: FRAC must lie in [0, DW)");
    end

    logic [1:0]      r_state;
    logic [DCW-1:0]  r_drain;
    logic [LOG2N:0]  r_cnt;
    logic [LAT-1:0]  r_vpipe;
    logic [4*DW-1:0] r_mean;
    logic [4*DW-1:0] w_mean;
    logic            w_accept;
    logic            w_acc_en;

    assign w_accept   = start && (r_state == S_IDLE);
    assign en_mul     = sample_valid && (r_state == S_RUN);
    assign sample_ack = en_mul;
    assign busy       = r_state != S_IDLE;
    assign done       = r_state == S_DIV;
    assign issued_cnt = r_cnt;
    // The fresh mean is shown combinationally in the done cycle, then held.
    assign mean_out   = done ? w_mean : r_mean;
    assign w_acc_en   = r_vpipe[LAT-1];

    always_ff @(posedge clk_acc or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
            r_mean  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (en_mul) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= S_DRAIN;
                            r_drain <= DCW'(LAT);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DCW'(1)) r_state <= S_DIV;
                    else r_drain <= r_drain - 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mean  <= w_mean;
                end
            endcase
        end
    end

    // Valid pipe tracks which MUL4 outputs belong to issued products.
    if (LAT == 1) begin : g_pipe1
        always_ff @(posedge clk_acc or negedge rst_n) begin
            if (!rst_n) r_vpipe <= '0;
            else r_vpipe <= en_mul;
        end
    end else begin : g_pipen
        always_ff @(posedge clk_acc or negedge rst_n) begin
            if (!rst_n) r_vpipe <= '0;
            else r_vpipe <= {r_vpipe[LAT-2:0], en_mul};
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic signed [AW-1:0] r_acc;
        logic signed [DW-1:0] w_in;
        assign w_in = in_data[k*DW +: DW];
        // Mean of in-range samples always fits DW, so truncation is exact.
        assign w_mean[k*DW +: DW] = DW'(r_acc >>> LOG2N);
        always_ff @(posedge clk_acc or negedge rst_n) begin
            if (!rst_n) r_acc <= '0;
            else if (w_accept) r_acc <= '0;
            else if (w_acc_en) r_acc <= r_acc + AW'(w_in);
        end
    end
endmodule

// File: tb/tb_mean_acc4.sv
// tb_mean_acc4: random and directed checks of mean_acc4 against a behavioural model.
module tb_mean_acc4;
    localparam int DW    = 26;
    localparam int LOG2N = 2;
    localparam int LAT   = 1;
    localparam int N     = 1 << LOG2N;

    logic              clk_acc = 0;
    logic              rst_n = 0;
    logic              start = 0;
    logic              sample_valid = 0;
    logic              en_mul;
    logic              sample_ack;
    logic [4*DW-1:0]   in_data = '0;
    logic              busy;
    logic              done;
    logic [4*DW-1:0]   mean_out;
    logic [LOG2N:0]    issued_cnt;

    mean_acc4 #(.DW(DW), .FRAC(13), .LOG2N(LOG2N), .LAT(LAT)) dut (
        .clk_acc(clk_acc), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
        .en_mul(en_mul), .sample_ack(sample_ack), .in_data(in_data), .busy(busy),
        .done(done), .mean_out(mean_out), .issued_cnt(issued_cnt)
    );

    always #5 clk_acc = ~clk_acc;

    int total = 0;
    int bad = 0;
    int smp[N][4];

    bit     m_coll = 0;
    bit     m_busy = 0;
    bit     m_done = 0;
    bit     m_was_done = 0;
    int     m_cnt = 0;
    int     m_tail = 0;
    longint m_sum[4] = '{default: 0};
    longint m_mean[4] = '{default: 0};

    function automatic longint floor_div(longint s);
        longint r;
        r = s % N;
        if (r < 0) r += N;
        return (s - r) / N;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint lane(int k);
        return $signed(mean_out[k*DW +: DW]);
    endfunction

    // MUL4 stand-in plus the reference model of what the accumulator must report.
    always @(posedge clk_acc or negedge rst_n) begin
        if (!rst_n) begin
            in_data <= '0;
            m_coll = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_tail = 0;
            for (int k = 0; k < 4; k++) begin m_sum[k] = 0; m_mean[k] = 0; end
        end else begin
            for (int k = 0; k < 4; k++)
                in_data[k*DW +: DW] <= en_mul ? DW'(smp[m_cnt % N][k]) : DW'($urandom);
            m_was_done = m_done;
            m_done = 0;
            if (!m_busy && start) begin
                m_busy = 1; m_coll = 1; m_cnt = 0;
                for (int k = 0; k < 4; k++) m_sum[k] = 0;
            end else if (m_coll && sample_valid) begin
                for (int k = 0; k < 4; k++) m_sum[k] += smp[m_cnt][k];
                m_cnt++;
                if (m_cnt == N) begin m_coll = 0; m_tail = LAT; end
            end else if (m_tail > 0) begin
                m_tail--;
                if (m_tail == 0) begin
                    m_done = 1;
                    for (int k = 0; k < 4; k++) m_mean[k] = floor_div(m_sum[k]);
                end
            end else if (m_was_done) m_busy = 0;
        end
    end

    always @(negedge clk_acc) begin
        chk("en_mul", en_mul, m_coll && sample_valid);
        chk("sample_ack", sample_ack, m_coll && sample_valid);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("issued_cnt", issued_cnt, m_cnt);
        for (int k = 0; k < 4; k++) chk($sformatf("mean_lane%0d", k), lane(k), m_mean[k]);
    end

    task automatic step();
        @(posedge clk_acc);
        #1;
    endtask

    task automatic fill(input int a, input int b, input int c, input int d);
        for (int i = 0; i < N; i++) begin
            smp[i][0] = a; smp[i][1] = b; smp[i][2] = c; smp[i][3] = d;
        end
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin step(); cyc++; end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_est(output int cyc);
        sample_valid = 1;
        pulse_start();
        wait_done(cyc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        fill(0, 0, 0, 0);
        repeat (2) step();
        chk("reset_busy", busy, 0);
        chk("reset_mean0", lane(0), 0);
        rst_n = 1;
        step();

        fill(8192, 8192, 8192, 8192);
        run_est(c);
        chk("t1_latency", c, 5);
        for (int k = 0; k < 4; k++) chk("t1_mean", lane(k), 8192);
        step();

        fill(0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            smp[i][0] = (i == N - 1) ? 2 : 1;
            smp[i][1] = (i == N - 1) ? -2 : -1;
        end
        run_est(c);
        chk("t2_lane0", lane(0), 1);
        chk("t2_lane1", lane(1), -2);
        chk("t2_lane2", lane(2), 0);
        chk("t2_lane3", lane(3), 0);
        step();

        fill(33554431, 33554431, 33554431, 33554431);
        run_est(c);
        for (int k = 0; k < 4; k++) chk("t3_max", lane(k), 33554431);
        step();
        fill(-33554432, -33554432, -33554432, -33554432);
        run_est(c);
        for (int k = 0; k < 4; k++) chk("t3_min", lane(k), -33554432);
        step();

        fill(10, -10, 3, -3);
        sample_valid = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            sample_valid = pat[i][0];
            start = (i == 2);
            step();
        end
        sample_valid = 0;
        start = 0;
        chk("t4_cnt", issued_cnt, 4);
        chk("t4_drain_done", done, 0);
        step();
        chk("t4_done", done, 1);
        chk("t4_lane0", lane(0), 10);
        chk("t4_lane1", lane(1), -10);
        chk("t4_lane3", lane(3), -3);
        step();

        fill(5000, 5000, 5000, 5000);
        sample_valid = 1;
        pulse_start();
        step();
        step();
        rst_n = 0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_en", en_mul, 0);
        chk("t5_cnt", issued_cnt, 0);
        chk("t5_mean0", lane(0), 0);
        step();
        rst_n = 1;
        step();
        fill(100, 100, 100, 100);
        run_est(c);
        for (int k = 0; k < 4; k++) chk("t5_mean", lane(k), 100);
        step();

        fill(7, 7, 7, 7);
        run_est(c);
        fill(9, 9, 9, 9);
        start = 1;
        step();
        chk("t6_ignored", busy, 0);
        step();
        start = 0;
        chk("t6_accepted", busy, 1);
        chk("t6_hold", lane(0), 7);
        wait_done(c);
        for (int k = 0; k < 4; k++) chk("t6_mean", lane(k), 9);
        step();

        repeat (8) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 4; k++) smp[i][k] = int'($urandom) >>> 6;
            pulse_start();
            c = 0;
            while (!done && c < 400) begin
                sample_valid = ($urandom % 3) != 0;
                start = ($urandom % 6) == 0;
                step();
                c++;
            end
            if (!done) chk("rand_timeout", 0, 1);
            start = 0;
            sample_valid = $urandom % 2;
            step();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mean_acc4.md
Name: mean_acc4

Overview:
- Consumer end of the MUL4 product interface: drives MUL4's enable, collects its registered 4-lane outputs over N = 2^LOG2N samples, and returns the per-lane sample mean E{z·g(wᵀz)} in the same Q(DW-FRAC).FRAC format.
- Sits between the sample-memory sequencer and the weight-update stage of the one-unit FastICA datapath.
- One instance serves one output row (o*1..o*4). Four instances cover the full 4x4 result.

Parameters:
- DW, 26, lane width, signed fixed point.
- FRAC, 13, fractional bits. Documentation only; no rescaling is done here.
- LOG2N, 10, log2 of samples per estimate (N = 1024).
- LAT, 1, cycles from en_mul high to the valid product at in_data (MUL4 registers once).
- AW, DW+LOG2N+1, accumulator width per lane.

Ports:
- clk_acc, input, 1, rising-edge clock shared with clk_mul.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins one estimate.
- sample_valid, input, 1, sequencer has a z/(zTw)^3 sample on MUL4's inputs this cycle.
- en_mul, output, 1, connects to MUL4 en_mul; high = product issued.
- sample_ack, output, 1, equals en_mul; the sequencer advances its address on it.
- in_data, input, 4*DW, MUL4 row outputs; lane k = bits [k*DW+DW-1 : k*DW], with o_1 in lane 0.
- busy, output, 1, high from the start acceptance through the cycle done is asserted (inclusive).
- done, output, 1, single-cycle pulse when mean_out is updated.
- mean_out, output, 4*DW, per-lane mean, same lane packing, held until the next done.
- issued_cnt, output, LOG2N+1, number of products issued in the current estimate.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; en_mul=0, busy=0, done=0, mean_out=0, issued_cnt=0; accumulators=0; valid pipe=0.
- States:
  - IDLE -> RUN on start. Accumulators cleared and issued_cnt zeroed in the same edge.
  - RUN: en_mul = sample_valid (combinational, gated by state). Each cycle with en_mul=1 increments issued_cnt. When an issue brings issued_cnt to N, go DRAIN on that edge.
  - DRAIN: en_mul=0. Stay LAT cycles; counter reloads to LAT on entry. Then go DIV.
  - DIV: mean_out lane k = acc_k >>> LOG2N, arithmetic shift (floor toward -inf), truncated to DW. The mean of N in-range DW values always fits DW, so no saturation is needed. done=1 this cycle. Next state IDLE.
- Valid pipeline: LAT-deep shift register of en_mul. Its output acc_en adds sign-extended in_data lanes into acc_k. Accumulation continues in DRAIN until the pipe empties.
- Accumulator width is AW, so the sum of N worst-case values never wraps. Exactly N products are accumulated per estimate.
- sample_valid low in RUN: no issue, counter holds, pipe inserts a bubble. Arbitrary gaps are allowed.
- start while busy: ignored. No restart or queueing.
- start in the same cycle as DIV: ignored, because busy=1. Accepted from the next cycle.
- rst_n low mid-estimate: immediate abort to reset values. The partial sum is discarded and the previous mean_out is cleared to 0.
- en_mul is never high outside RUN. issued_cnt never exceeds N.
- Latency with sample_valid always 1: start edge -> N RUN cycles -> LAT DRAIN -> DIV. done comes N+LAT+1 cycles after the start-accept edge.

Test Plan:
- LOG2N=2, LAT=1, all lanes 8192 (1.0 Q13) for 4 samples, sample_valid=1 -> en_mul high exactly 4 cycles, done at cycle 6 after start, every lane of mean_out = 8192.
- Rounding: lane0 products 1,1,1,2 and lane1 -1,-1,-1,-2 -> lane0 = 1, lane1 = -2 (floor); lanes 2/3 = 0.
- Extremes: LOG2N=10, all lanes 33554431 for 1024 samples, then all -33554432 -> means 33554431 and -33554432; no accumulator wrap.
- Stall: sample_valid pattern 1,0,0,1,1,0,1 with N=4 -> en_mul mirrors valid only in RUN, issued_cnt reaches 4 at the 4th one, done 2 cycles later; a second start pulse during busy is ignored.
- Reset: rst_n asserted after 2 of 4 samples -> all outputs 0 immediately. A new start then produces a mean from 4 fresh samples only (all 100 -> 100).
- Back-to-back: start in the DIV cycle is ignored; start one cycle later is accepted, and mean_out holds the old value until the new done.
